// File: rtl/fifo_pkg.sv
// Shared definitions for param_fifo: controller state encodings and a constant clog2 helper.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PROC  = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    // Smallest n with 2**n >= value; usable in constant expressions (port widths).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/param_fifo_edge_detector.sv
// Registered edge detector: one-cycle pulse per selected edge of a level input.
module edge_detector #(
    parameter bit FALLING = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_reg;
    logic pulse_reg;

    // The idle level is the inactive one, so no spurious edge appears right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg <= FALLING;
            pulse_reg <= 1'b0;
        end else begin
            level_reg <= level;
            pulse_reg <= FALLING ? (level_reg & ~level) : (~level_reg & level);
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with a three-state controller and sticky error flags.
// Optional build macro PARAM_FIFO_BTN_EDGE_EN: push/pop become active-low buttons, one request per falling edge.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dout,
    output logic [clog2(DEPTH+1)-1:0]  count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic push_req;
    logic pop_req;

`ifdef PARAM_FIFO_BTN_EDGE_EN
    edge_detector #(.FALLING(1'b1)) u_push_edge (
        .clk   (clk),
        .reset (reset),
        .level (push),
        .pulse (push_req)
    );
    edge_detector #(.FALLING(1'b1)) u_pop_edge (
        .clk   (clk),
        .reset (reset),
        .level (pop),
        .pulse (pop_req)
    );
`else
    assign push_req = push;
    assign pop_req  = pop;
`endif

    fifo_state_t      state_reg, state_next;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             overflow_reg, underflow_reg;
    logic             do_write, do_read, set_ov, set_un;

    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_next = state_reg;
        do_write   = 1'b0;
        do_read    = 1'b0;
        set_ov     = 1'b0;
        set_un     = 1'b0;
        case (state_reg)
            EMPTY: begin
                set_un = pop_req;
                if (push_req) begin
                    do_write   = 1'b1;
                    state_next = PROC;
                end
            end
            PROC: begin
                do_write = push_req;
                do_read  = pop_req;
                if (push_req && !pop_req && count_reg == CW'(DEPTH - 1)) begin
                    state_next = FULL;
                end else if (pop_req && !push_req && count_reg == CW'(1)) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop_req) begin
                    do_read  = 1'b1;
                    do_write = push_req;
                    if (!push_req) begin
                        state_next = PROC;
                    end
                end else begin
                    set_ov = push_req;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (do_write && !do_read) begin
            count_next = count_reg + CW'(1);
        end else if (do_read && !do_write) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            // Read-before-write: a same-edge write to the head slot shows up one edge later.
            dout_reg   <= mem[rd_ptr_reg];
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_read) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            overflow_reg  <= clr_err ? 1'b0 : (overflow_reg | set_ov);
            underflow_reg <= clr_err ? 1'b0 : (underflow_reg | set_un);
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign dout         = dout_reg;
    assign count        = count_reg;
    assign full         = (state_reg == FULL);
    assign empty        = (state_reg == EMPTY);
    assign almost_full  = (int'(count_reg) >= DEPTH - AF_MARGIN);
    assign almost_empty = (int'(count_reg) <= AE_MARGIN);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: vector table, directed corner sequences and a queue-based random model.
module tb_param_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 2;
    localparam int AE_MARGIN = 2;
    localparam int CW        = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    int n_vec  = 0;
    int n_miss = 0;

    int q[$];
    bit m_ov;
    bit m_un;

    typedef struct {
        bit         p;
        bit         r;
        bit         c;
        logic [7:0] d;
        int         cnt;
        bit         emp;
        bit         un;
        bit         dchk;
        logic [7:0] dexp;
    } vec_t;

    vec_t tbl[12];

    param_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .AE_MARGIN (AE_MARGIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .din          (din),
        .clr_err      (clr_err),
        .dout         (dout),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit idle);
        @(negedge clk);
        reset = 1'b1; push = idle; pop = idle; din = '0; clr_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic cycle(input bit p, input bit r, input logic [7:0] d, input bit c);
        @(negedge clk);
        push = p; pop = r; din = d; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    // Queue model: what the FIFO holds, and which word the head register should show after this edge.
    task automatic model_step(input bit p, input bit r, input logic [7:0] d, input bit c,
                              output bit dv, output int dexp);
        dv   = (q.size() > 0);
        dexp = dv ? q[0] : 0;
        if (p && r) begin
            if (q.size() == 0) begin
                q.push_back(int'(d));
                m_un = 1'b1;
            end else begin
                void'(q.pop_front());
                q.push_back(int'(d));
            end
        end else if (p) begin
            if (q.size() == DEPTH) m_ov = 1'b1;
            else q.push_back(int'(d));
        end else if (r) begin
            if (q.size() == 0) m_un = 1'b1;
            else void'(q.pop_front());
        end
        if (c) begin
            m_ov = 1'b0;
            m_un = 1'b0;
        end
    endtask

    task automatic step(input bit p, input bit r, input logic [7:0] d, input bit c, input string tag);
        bit dv;
        int dexp;
        cycle(p, r, d, c);
        model_step(p, r, d, c, dv, dexp);
        check({tag, " count"}, 32'(count), 32'(q.size()));
        check({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, " almost_full"}, 32'(almost_full), 32'(q.size() >= DEPTH - AF_MARGIN));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE_MARGIN));
        check({tag, " overflow"}, 32'(overflow), 32'(m_ov));
        check({tag, " underflow"}, 32'(underflow), 32'(m_un));
        if (dv) check({tag, " dout"}, 32'(dout), 32'(dexp));
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, " count"}, 32'(count), 32'd0);
        check({tag, " empty"}, 32'(empty), 32'd1);
        check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, " full"}, 32'(full), 32'd0);
        check({tag, " almost_full"}, 32'(almost_full), 32'd0);
        check({tag, " dout"}, 32'(dout), 32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
        m_ov = 1'b0; m_un = 1'b0;

`ifdef PARAM_FIFO_BTN_EDGE_EN
        do_reset(1'b1);
        #1;
        check_idle_reset("btn reset");
        // Button held low ten cycles: exactly one write.
        @(negedge clk);
        push = 1'b0; din = 8'h5A;
        repeat (10) @(negedge clk);
        push = 1'b1;
        repeat (3) @(negedge clk);
        check("btn hold push count", 32'(count), 32'd1);
        check("btn hold push dout", 32'(dout), 32'h5A);
        check("btn overflow", 32'(overflow), 32'd0);
        pop = 1'b0;
        repeat (4) @(negedge clk);
        pop = 1'b1;
        repeat (3) @(negedge clk);
        check("btn hold pop count", 32'(count), 32'd0);
        check("btn hold pop empty", 32'(empty), 32'd1);
        check("btn underflow", 32'(underflow), 32'd0);
        // Two separate presses give two writes, each one cycle after its falling edge.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            push = 1'b0;
            @(posedge clk); #1;
            check("btn latency no write yet", 32'(count), 32'(i));
            @(posedge clk); #1;
            check("btn latency write", 32'(count), 32'(i + 1));
            @(negedge clk);
            push = 1'b1;
        end
`else
        do_reset(1'b0);
        #1;
        check_idle_reset("reset");

        // Table of short single-cycle behaviours, expectations worked out by hand.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'hA1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'hA2, 1, 1'b0, 1'b0, 1'b1, 8'hA1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'hA2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'hA2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'hB3, 1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'hB3};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'hC4, 2, 1'b0, 1'b0, 1'b1, 8'hB3};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'hB3};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'hC4};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].p, tbl[i].r, tbl[i].d, tbl[i].c);
            check($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d empty", i), 32'(empty), 32'(tbl[i].emp));
            check($sformatf("tbl%0d underflow", i), 32'(underflow), 32'(tbl[i].un));
            check($sformatf("tbl%0d overflow", i), 32'(overflow), 32'd0);
            if (tbl[i].dchk) check($sformatf("tbl%0d dout", i), 32'(dout), 32'(tbl[i].dexp));
        end

        // Fill to full, overflow, then drain in order and underflow.
        do_reset(1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0, $sformatf("fill%0d", i));
            check($sformatf("fill%0d af", i), 32'(almost_full), 32'(i >= 14));
        end
        check("filled full", 32'(full), 32'd1);
        check("filled count", 32'(count), 32'd16);
        step(1'b1, 1'b0, 8'hEE, 1'b0, "push17");
        check("push17 overflow", 32'(overflow), 32'd1);
        check("push17 count", 32'(count), 32'd16);
        step(1'b0, 1'b0, 8'h00, 1'b1, "clr");
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, $sformatf("drain%0d", i));
            check($sformatf("drain%0d order", i), 32'(dout), 32'(i));
        end
        check("drained empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0, "pop_empty");
        check("pop_empty underflow", 32'(underflow), 32'd1);

        // Pointer wrap: 8 in, 8 out, 12 in, 12 out.
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, "wrap_in8");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "wrap_out8");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, "wrap_in12");
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, "wrap_out12");
            check($sformatf("wrap word%0d", i), 32'(dout), 32'(8'h40 + i));
        end

        // Simultaneous push and pop at counts 0, 5 and 16.
        do_reset(1'b0);
        step(1'b1, 1'b1, 8'h11, 1'b0, "pp_at0");
        check("pp_at0 count", 32'(count), 32'd1);
        check("pp_at0 underflow", 32'(underflow), 32'd1);
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, "pp5_fill");
        step(1'b1, 1'b1, 8'h77, 1'b0, "pp_at5");
        check("pp_at5 count", 32'(count), 32'd5);
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, "pp16_fill");
        step(1'b1, 1'b1, 8'h99, 1'b0, "pp_at16");
        check("pp_at16 count", 32'(count), 32'd16);
        check("pp_at16 overflow", 32'(overflow), 32'd0);
        check("pp_at16 full", 32'(full), 32'd1);

        // Asynchronous reset mid-operation at count 7 with a flag set.
        do_reset(1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, "pre_async_un");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0, "async_fill");
        step(1'b0, 1'b0, 8'h00, 1'b0, "async_idle");
        check("async pre count", 32'(count), 32'd7);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_idle_reset("async reset");
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;

        // Random traffic against the queue model, alternating fill-heavy and drain-heavy phases.
        for (int i = 0; i < 600; i++) begin
            int pbias;
            bit p, r, c;
            pbias = ((i / 100) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < pbias);
            r = ($urandom_range(0, 99) < (100 - pbias));
            c = ($urandom_range(0, 24) == 0);
            step(p, r, 8'($urandom), c, $sformatf("rnd%0d", i));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data word width in bits (1..32).
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning the number of entries (a power of two, 2..256).
REQ-003 The module SHALL have parameter AF_MARGIN, default 2, meaning almost_full asserts when count >= DEPTH-AF_MARGIN.
REQ-004 The module SHALL have parameter AE_MARGIN, default 2, meaning almost_empty asserts when count <= AE_MARGIN.
REQ-005 The module SHALL have port clk, input, 1 bit: the clock.
REQ-006 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port push, input, 1 bit: the write request.
REQ-008 The module SHALL have port pop, input, 1 bit: the read request.
REQ-009 The module SHALL have port din, input, WIDTH bits: the write data.
REQ-010 The module SHALL have port clr_err, input, 1 bit: a synchronous clear of the sticky error flags.
REQ-011 The module SHALL have port dout, output, WIDTH bits: the registered head-of-queue word.
REQ-012 The module SHALL have port count, output, $clog2(DEPTH+1) bits: the occupancy.
REQ-013 The module SHALL have outputs full, empty, almost_full and almost_empty, each 1 bit: combinational decodes of the state and count.
REQ-014 The module SHALL have outputs overflow and underflow, each 1 bit: sticky error flags.

Function
REQ-015 The controller SHALL be a three-state FSM with states EMPTY, PROC and FULL; full SHALL equal (state==FULL) and empty SHALL equal (state==EMPTY).
REQ-016 An accepted push SHALL write din to mem[wr_ptr] and increment wr_ptr modulo DEPTH, with natural wrap from DEPTH-1 to 0.
REQ-017 An accepted pop SHALL increment rd_ptr modulo DEPTH, with natural wrap.
REQ-018 dout SHALL load mem[rd_ptr] on every clock edge, so a word written at edge k appears on dout after edge k+1.
REQ-019 In EMPTY: push SHALL be accepted and move the FSM to PROC; pop SHALL be ignored and set underflow; push and pop together SHALL accept the push only and set underflow.
REQ-020 In PROC: push and pop SHALL each be accepted; push and pop together SHALL leave count unchanged and the state unchanged.
REQ-021 In PROC: a push alone that makes count==DEPTH SHALL move to FULL; a pop alone that makes count==0 SHALL move to EMPTY.
REQ-022 In FULL: push alone SHALL be ignored and set overflow, with memory unmodified; pop alone SHALL move to PROC; push and pop together SHALL accept both and remain in FULL.
REQ-023 count SHALL change by +1 on a lone accepted push, by -1 on a lone accepted pop, and otherwise hold; it SHALL never leave 0..DEPTH.
REQ-024 overflow and underflow SHALL stay set until clr_err or reset; clr_err SHALL take priority over a same-cycle set.

Reset
REQ-025 Asserting reset SHALL immediately force state=EMPTY, wr_ptr=0, rd_ptr=0, count=0, dout=0, overflow=0 and underflow=0, including mid-operation; memory contents SHALL NOT be reset.
REQ-026 After reset, empty=1, almost_empty=1, full=0 and almost_full=0.

Configuration
REQ-027 With macro PARAM_FIFO_BTN_EDGE_EN defined, push and pop SHALL be active-low button levels, each passed through an edge_detector in falling-edge mode; one request SHALL occur per falling edge, with one added cycle of latency.
REQ-028 Without PARAM_FIFO_BTN_EDGE_EN, push and pop SHALL be active-high synchronous strobes, acted on in every cycle they are high.

Structure
REQ-029 Package fifo_pkg SHALL hold the state encodings (EMPTY=0, PROC=1, FULL=2) and the clog2 helper function.
REQ-030 The edge_detector SHALL be the only sub-module and SHALL be instantiated only under PARAM_FIFO_BTN_EDGE_EN.

Verification
REQ-031 With DEPTH=16, 16 pushes of 0x01..0x10 SHALL give full=1, count=16 and almost_full asserted from count 14; a 17th push SHALL set overflow=1 with count=16.
REQ-032 16 pops after the fill SHALL present dout 0x01..0x10 in order, then empty=1; a further pop SHALL set underflow=1.
REQ-033 Push 8, pop 8, then push 12 SHALL wrap the pointers, and the data SHALL read back 12 words in order.
REQ-034 Simultaneous push and pop at count=0 SHALL give count=1 with underflow set; at count=5 count SHALL stay 5; at count=16 count SHALL stay 16 with no overflow.
REQ-035 Asserting reset at count=7 SHALL give count=0, empty=1, dout=0 and flags=0 before the next clk edge.
REQ-036 With PARAM_FIFO_BTN_EDGE_EN, push held low for 10 cycles SHALL give exactly one write (count=1).
